truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Hardware stimulus/response end of the boolean-expression flow: drives every input combination into a combinational expression block and captures its output F per vector.
- Builds the captured truth table, compares it against an expected table latched at start, and reports the mismatch count.
- Sits beside any boolN expression module for in-silicon/FPGA self-check; replaces hand-written sweep stimulus.

Parameters:
- N_IN, 3, number of expression inputs; vec_out[N_IN-1] is A (MSB), vec_out[0] is C for N_IN=3.
- SETTLE, 2, clock cycles each vector is held before F is sampled; legal range >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; honoured only in IDLE.
- expected  in  2**N_IN  expected truth table; bit i = F for vec i; latched on accepted start.
- f_in  in  1  F output of the expression block under test.
- vec_out  out  N_IN  current input vector {A,B,C,...} to the expression block.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at end of sweep.
- table_out  out  2**N_IN  captured truth table; bit i = f_in sampled for vec i.
- err_count  out  N_IN+1  number of bits where table_out != latched expected.
- mismatch  out  1  err_count != 0; valid from done onward.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; vec_out=0, busy=0, done=0, table_out=0, err_count=0, mismatch=0, settle counter=0, latched expected=0. Reset mid-sweep aborts immediately; no done pulse.
- States: IDLE, DRIVE, DONE.
- IDLE: start=1 -> latch expected, vec_out<=0, cnt<=0, table_out<=0, err_count<=0, mismatch<=0, busy<=1, go DRIVE. start=0 -> hold all outputs (results persist).
- DRIVE: vec_out held; cnt increments each cycle. At the edge where cnt==SETTLE-1: table_out[vec_out]<=f_in; err_count += (f_in != exp_l[vec_out]); cnt<=0; if vec_out==2**N_IN-1 go DONE, else vec_out<=vec_out+1.
- Each vector held exactly SETTLE cycles; f_in sampled at the final edge of the hold.
- DONE (one cycle): busy=0, done=1, mismatch=(final err_count!=0); vec_out holds last vector; next state IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0 + 2**N_IN*SETTLE (N_IN=3, SETTLE=2: 16 cycles).
- start while busy or in DONE: ignored; no restart, no effect on results.
- expected changes during a sweep: no effect (latched copy used).
- err_count cannot overflow: max 2**N_IN fits in N_IN+1 bits.
- vec_out wrap-around never occurs; last vector terminates the sweep.
- f_in treated as registered-sample only; no combinational path from f_in to any output.

Decomposition:
- Shared package tt_pkg: state enum {IDLE, DRIVE, DONE}; localparam NVEC = 2**N_IN helper; SETTLE width function (clog2 of SETTLE, min 1).
- One sub-module: settle_timer (load/clear, count to SETTLE-1, terminal-count pulse). Vector counter, capture and compare stay in the top.

Test Plan:
- Model F=(A&~B)|C, expected=8'hBA, SETTLE=2, pulse start -> vec_out steps 0..7 two cycles each; done 16 cycles after start; table_out=8'hBA, err_count=0, mismatch=0.
- Same model, expected=8'hBB -> table_out=8'hBA, err_count=1, mismatch=1 at done; results held in IDLE until next start.
- SETTLE=1 instance, expected=8'hBA -> one cycle per vector; done 8 cycles after start; err_count=0.
- start held high for whole sweep and pulsed again mid-sweep -> single sweep only; exactly one done pulse; a new sweep starts only after returning to IDLE.
- rst asserted while vec_out=3 -> next cycle all outputs 0, state IDLE, no done; subsequent start gives a clean full sweep with table_out=8'hBA.
- expected changed from 8'hBA to 8'h00 mid-sweep -> err_count=0 (latched value used).

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of input vectors (truth-table rows) for n_in inputs.
    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

    // Width of the settle counter: holds 0..settle-1, never narrower than 1 bit.
    function automatic int settle_w(input int settle);
        return (settle <= 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle timer: counts the hold cycles of one vector and flags the last one.
// tc is high during the final cycle of the hold, so the edge that ends the
// cycle is the sampling edge for the expression output.
module settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int W      = settle_w(SETTLE)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(SETTLE - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    // Count while enabled, wrap to zero on terminal count, clear outside a sweep.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input vector through an external
// combinational expression, captures F per vector after it settles,
// and compares the captured table against an expected table latched at start.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        err_count,
    output logic                 mismatch
);

    localparam int              NV       = nvec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    state_t          state;
    logic [NV-1:0]   exp_l;
    logic            tc;
    logic            miss;
    logic [N_IN:0]   err_next;

    // Hold timer runs only while driving; it is parked at zero otherwise so
    // every sweep starts with a full hold on vector 0.
    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state != DRIVE),
        .en    (state == DRIVE),
        .tc    (tc)
    );

    // Per-vector compare result and the running error count including it;
    // only ever consumed by registers on the sampling edge.
    always_comb begin
        miss     = f_in ^ exp_l[vec_out];
        err_next = err_count + {{N_IN{1'b0}}, miss};
    end

    // Sweep controller: accept start, step vectors on terminal count, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exp_l     <= '0;
            vec_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            err_count <= '0;
            mismatch  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // Results from the previous sweep persist until a new start.
                    if (start) begin
                        exp_l     <= expected;
                        vec_out   <= '0;
                        table_out <= '0;
                        err_count <= '0;
                        mismatch  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (tc) begin
                        table_out[vec_out] <= f_in;
                        err_count          <= err_next;
                        if (vec_out == LAST_VEC) begin
                            // Last row captured: vec_out stays on it through DONE.
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mismatch <= (err_next != '0);
                            state    <= DONE;
                        end else begin
                            vec_out <= vec_out + 1'b1;
                        end
                    end
                end

                DONE: begin
                    // One-cycle done pulse; start is ignored here.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
